// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle ARM control unit.
// Optional feature macro: MC_CTRL_SHIFT_EN (enables MOV, cmd 1101).
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    // Instr[27:26]
    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Instr[24:21]
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_SHOUT  = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    // Data-processing commands this build can execute; anything else aborts in DECODE.
    function automatic logic dp_cmd_ok(input logic [3:0] cmd);
        case (cmd)
            CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR, CMD_CMP: return 1'b1;
`ifdef MC_CTRL_SHIFT_EN
            CMD_MOV: return 1'b1;
`else
            CMD_MOV: return 1'b0;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_ctl(input logic [3:0] cmd);
        case (cmd)
            CMD_SUB, CMD_CMP: return ALU_SUB;
            CMD_AND:          return ALU_AND;
            CMD_ORR:          return ALU_ORR;
            default:          return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath bus: instruction/flags in, selects and enables out.
interface mc_controller_if;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, IRWrite, RegWrite, MemWrite;
    logic        AdrSrc, ALUSrcA, Shift;
    logic [1:0]  RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl;

    modport master (
        input  Instr, ALUFlags,
        output PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Shift,
               RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl
    );

    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, Shift,
               RegSrc, ImmSrc, ALUSrcB, ResultSrc, ALUControl
    );
endinterface

// File: rtl/mc_condcheck.sv
// ARM condition-field evaluation against an NZCV flags value.
module mc_condcheck (
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       cond_ex
);
    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    // One case per ARM condition code; 1111 never executes.
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z;
            4'b0001: cond_ex = ~z;
            4'b0010: cond_ex = c;
            4'b0011: cond_ex = ~c;
            4'b0100: cond_ex = n;
            4'b0101: cond_ex = ~n;
            4'b0110: cond_ex = v;
            4'b0111: cond_ex = ~v;
            4'b1000: cond_ex = c & ~z;
            4'b1001: cond_ex = ~c | z;
            4'b1010: cond_ex = (n == v);
            4'b1011: cond_ex = (n != v);
            4'b1100: cond_ex = ~z & (n == v);
            4'b1101: cond_ex = z | (n != v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control unit: Moore main FSM, NZCV flags and per-instruction condition bit.
// Optional feature macro: MC_CTRL_SHIFT_EN (MOV support via Shift output).
module mc_controller
    import mc_ctrl_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    mc_controller_if.master bus
);
    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       cond_q, cond_d;
    logic       cond_ex;

    logic [1:0] op;
    logic [3:0] cmd;
    logic       i_bit, u_bit, l_bit, rd_pc, is_cmp;
    assign op     = bus.Instr[27:26];
    assign i_bit  = bus.Instr[25];
    assign cmd    = bus.Instr[24:21];
    assign u_bit  = bus.Instr[23];
    assign l_bit  = bus.Instr[20];   // also the S bit for data processing
    assign rd_pc  = (bus.Instr[15:12] == 4'hF);
    assign is_cmp = (cmd == CMD_CMP);

    logic unused_instr;
    assign unused_instr = ^{bus.Instr[19:16], bus.Instr[11:0]};

    mc_condcheck u_condcheck (
        .cond    (bus.Instr[31:28]),
        .nzcv    (flags_q),
        .cond_ex (cond_ex)
    );

    // Next state; unsupported DP commands and Op=11 abort back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_MEM:  state_d = S_MEMADR;
                    OP_DP:   state_d = dp_cmd_ok(cmd) ? (i_bit ? S_EXECI : S_EXECR) : S_FETCH;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:         state_d = l_bit ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:        state_d = S_MEMWB;
            S_EXECR, S_EXECI: state_d = S_ALUWB;
            default:          state_d = S_FETCH;
        endcase
    end

    // Condition latched at end of DECODE; flags written at the EXEC edge when enabled.
    always_comb begin
        cond_d  = (state_q == S_DECODE) ? cond_ex : cond_q;
        flags_d = flags_q;
        if ((state_q == S_EXECR || state_q == S_EXECI) && cond_q && (l_bit || is_cmp)) begin
            if (cmd == CMD_ADD || cmd == CMD_SUB || is_cmp)
                flags_d = bus.ALUFlags;
            else
                flags_d[3:2] = bus.ALUFlags[3:2];
        end
    end

    // State, flags and condition registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            flags_q <= 4'b0000;
            cond_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cond_q  <= cond_d;
        end
    end

    // Output decode from state and instruction fields; reset forces FETCH selects, no writes.
    always_comb begin
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.Shift      = 1'b0;
        bus.RegSrc     = 2'b00;
        bus.ALUSrcB    = SRCB_REG;
        bus.ResultSrc  = RES_ALUOUT;
        bus.ALUControl = ALU_ADD;
        bus.ImmSrc     = (op == OP_MEM) ? 2'b01 : (op == OP_BR) ? 2'b10 : 2'b00;
        case (state_q)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.PCWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_4;
                bus.ResultSrc = RES_SHOUT;
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_4;
                bus.ResultSrc = RES_SHOUT;
            end
            S_MEMADR: begin
                bus.RegSrc     = 2'b10;
                bus.ALUSrcB    = SRCB_IMM;
                bus.ALUControl = u_bit ? ALU_ADD : ALU_SUB;
            end
            S_MEMREAD: begin
                bus.AdrSrc    = 1'b1;
                bus.ResultSrc = RES_ALUOUT;
            end
            S_MEMWB: begin
                bus.ResultSrc = RES_DATA;
                bus.RegWrite  = cond_q;
                bus.PCWrite   = cond_q & rd_pc;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.RegSrc   = 2'b10;
                bus.MemWrite = cond_q;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcB    = (state_q == S_EXECI) ? SRCB_IMM : SRCB_REG;
                bus.ALUControl = alu_ctl(cmd);
`ifdef MC_CTRL_SHIFT_EN
                bus.Shift      = (cmd == CMD_MOV);
`else
                bus.Shift      = 1'b0;
`endif
            end
            S_ALUWB: begin
                bus.ResultSrc = RES_ALUOUT;
                bus.RegWrite  = cond_q & ~is_cmp;
                bus.PCWrite   = cond_q & rd_pc;
            end
            S_BRANCH: begin
                bus.RegSrc    = 2'b01;
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_SHOUT;
                bus.PCWrite   = cond_q;
            end
            default: ;
        endcase
        if (reset) begin
            bus.PCWrite    = 1'b0;
            bus.IRWrite    = 1'b0;
            bus.RegWrite   = 1'b0;
            bus.MemWrite   = 1'b0;
            bus.AdrSrc     = 1'b0;
            bus.ALUSrcA    = 1'b1;
            bus.Shift      = 1'b0;
            bus.RegSrc     = 2'b00;
            bus.ALUSrcB    = SRCB_4;
            bus.ResultSrc  = RES_SHOUT;
            bus.ALUControl = ALU_ADD;
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller against an instruction-level reference model.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset;

    mc_controller_if bus();
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

`ifdef MC_CTRL_SHIFT_EN
    localparam bit HAS_MOV = 1'b1;
`else
    localparam bit HAS_MOV = 1'b0;
`endif

    typedef struct packed {
        logic pcw, irw, rgw, mw, adr, srca, sh;
        logic [1:0] regsrc, imm, srcb, res, aluc;
    } ob_t;

    typedef enum int {PF, PD, PMA, PMR, PMWB, PMW, PER, PEI, PAWB, PB} ph_e;

    int   n_chk = 0;
    int   n_err = 0;
    logic [3:0] m_flags = 4'b0000;
    ph_e  seq[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'h0: return z;           4'h1: return !z;
            4'h2: return cf;          4'h3: return !cf;
            4'h4: return n;           4'h5: return !n;
            4'h6: return v;           4'h7: return !v;
            4'h8: return cf && !z;    4'h9: return !cf || z;
            4'hA: return n == v;      4'hB: return n != v;
            4'hC: return !z && n == v; 4'hD: return z || n != v;
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit dp_known(input logic [3:0] cmd);
        return cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b0000 ||
               cmd == 4'b1100 || cmd == 4'b1010 || (HAS_MOV && cmd == 4'b1101);
    endfunction

    // Cycle-by-cycle walk an instruction takes, per its class.
    function automatic void build_seq(input logic [31:0] ins);
        seq.delete();
        seq.push_back(PF);
        seq.push_back(PD);
        case (ins[27:26])
            2'b01: begin
                seq.push_back(PMA);
                if (ins[20]) begin seq.push_back(PMR); seq.push_back(PMWB); end
                else seq.push_back(PMW);
            end
            2'b00: if (dp_known(ins[24:21])) begin
                seq.push_back(ins[25] ? PEI : PER);
                seq.push_back(PAWB);
            end
            2'b10: seq.push_back(PB);
            default: ;
        endcase
    endfunction

    function automatic void expect_for(input ph_e p, input logic [31:0] ins, input bit c,
                                       output ob_t e, output ob_t m);
        logic [3:0] cmd = ins[24:21];
        bit rd15 = (ins[15:12] == 4'hF);
        bit mov  = HAS_MOV && cmd == 4'b1101;
        e = '0;
        m = '0;
        m.pcw = 1; m.irw = 1; m.rgw = 1; m.mw = 1; m.sh = 1; m.regsrc = 2'b11; m.imm = 2'b11;
        e.imm = (ins[27:26] == 2'b01) ? 2'b01 : (ins[27:26] == 2'b10) ? 2'b10 : 2'b00;
        case (p)
            PF: begin
                e.pcw = 1; e.irw = 1;
                m.adr = 1; e.srca = 1; m.srca = 1; e.srcb = 2'b10; m.srcb = 2'b11;
                e.res = 2'b10; m.res = 2'b11; m.aluc = 2'b11;
            end
            PD: begin
                e.srca = 1; m.srca = 1; e.srcb = 2'b10; m.srcb = 2'b11; e.res = 2'b10; m.res = 2'b11;
            end
            PMA: begin
                e.regsrc = 2'b10; m.srca = 1; e.srcb = 2'b01; m.srcb = 2'b11;
                e.aluc = ins[23] ? 2'b00 : 2'b01; m.aluc = 2'b11;
            end
            PMR:  begin e.adr = 1; m.adr = 1; m.res = 2'b11; end
            PMWB: begin e.res = 2'b01; m.res = 2'b11; e.rgw = c; e.pcw = c && rd15; end
            PMW:  begin e.adr = 1; m.adr = 1; e.regsrc = 2'b10; e.mw = c; end
            PER, PEI: begin
                m.srca = 1; e.srcb = (p == PEI) ? 2'b01 : 2'b00; m.srcb = 2'b11;
                e.sh = mov;
                if (!mov) begin
                    m.aluc = 2'b11;
                    case (cmd)
                        4'b0100: e.aluc = 2'b00;
                        4'b0010, 4'b1010: e.aluc = 2'b01;
                        4'b0000: e.aluc = 2'b10;
                        default: e.aluc = 2'b11;
                    endcase
                end
            end
            PAWB: begin m.res = 2'b11; e.rgw = c && cmd != 4'b1010; e.pcw = c && rd15; end
            PB: begin
                e.regsrc = 2'b01; m.srca = 1; e.srcb = 2'b01; m.srcb = 2'b11;
                m.aluc = 2'b11; e.res = 2'b10; m.res = 2'b11; e.pcw = c;
            end
            default: ;
        endcase
    endfunction

    function automatic ob_t sample();
        ob_t o;
        o.pcw = bus.PCWrite;  o.irw = bus.IRWrite; o.rgw = bus.RegWrite; o.mw = bus.MemWrite;
        o.adr = bus.AdrSrc;   o.srca = bus.ALUSrcA; o.sh = bus.Shift;
        o.regsrc = bus.RegSrc; o.imm = bus.ImmSrc; o.srcb = bus.ALUSrcB;
        o.res = bus.ResultSrc; o.aluc = bus.ALUControl;
        return o;
    endfunction

    // Reset forces FETCH selects and no writes; ImmSrc still follows Op.
    task automatic check_reset_outs(input string tag);
        ob_t e;
        logic [16:0] ov, ev;
        e = '0;
        e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
        e.imm = (bus.Instr[27:26] == 2'b01) ? 2'b01 : (bus.Instr[27:26] == 2'b10) ? 2'b10 : 2'b00;
        ov = sample();
        ev = e;
        check(tag, 32'(ov), 32'(ev));
    endtask

    // Runs one instruction from FETCH; entered and left at posedge+1.
    // fl < 0 randomizes ALUFlags each cycle; rst_at >= 0 asserts reset in that cycle.
    task automatic run_instr(input string tag, input logic [31:0] ins, input int fl, input int rst_at);
        bit c;
        ob_t e, m;
        logic [16:0] ov, ev, mv;
        logic [3:0] f;
        build_seq(ins);
        c = cond_holds(ins[31:28], m_flags);
        bus.Instr = ins;
        for (int i = 0; i < seq.size(); i++) begin
            f = (fl < 0) ? 4'($urandom) : 4'(fl);
            bus.ALUFlags = f;
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                check({tag, ".rst"}, 32'(bus.MemWrite), 32'd0);
                check_reset_outs({tag, ".rstout"});
                @(posedge clk); #1;
                reset = 1'b0;
                m_flags = 4'b0000;
                check({tag, ".rstflg"}, 32'(dut.flags_q), 32'd0);
                return;
            end
            @(negedge clk);
            expect_for(seq[i], ins, c, e, m);
            ov = sample(); ev = e; mv = m;
            check($sformatf("%s.%0d", tag, i), 32'(ov & mv), 32'(ev & mv));
            @(posedge clk); #1;
            if ((seq[i] == PER || seq[i] == PEI) && c && (ins[20] || ins[24:21] == 4'b1010)) begin
                if (ins[24:21] inside {4'b0100, 4'b0010, 4'b1010}) m_flags = f;
                else m_flags[3:2] = f[3:2];
            end
        end
        check({tag, ".flags"}, 32'(dut.flags_q), 32'(m_flags));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 1) == 0) r[31:28] = 4'hE;
        if (r[27:26] == 2'b00 && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 5))
                0: r[24:21] = 4'b0100;
                1: r[24:21] = 4'b0010;
                2: r[24:21] = 4'b0000;
                3: r[24:21] = 4'b1100;
                4: r[24:21] = 4'b1010;
                default: r[24:21] = 4'b1101;
            endcase
        end
        return r;
    endfunction

    localparam logic [31:0] ADDS   = {4'hE, 2'b00, 1'b0, 4'b0100, 1'b1, 4'h2, 4'h1, 8'h00, 4'h3};
    localparam logic [31:0] CMP_RR = {4'hE, 2'b00, 1'b0, 4'b1010, 1'b1, 4'h2, 4'h0, 8'h00, 4'h3};
    localparam logic [31:0] BEQ    = {4'h0, 2'b10, 2'b10, 24'h000010};
    localparam logic [31:0] BNE    = {4'h1, 2'b10, 2'b10, 24'h000010};
    localparam logic [31:0] LDR_D  = {4'hE, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 4'h2, 12'h008};
    localparam logic [31:0] STRNE  = {4'h1, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 12'h004};
    localparam logic [31:0] STR_AL = {4'hE, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1, 4'h2, 12'h004};
    localparam logic [31:0] MOV_I  = {4'hE, 2'b00, 1'b1, 4'b1101, 1'b0, 4'h0, 4'h0, 12'h005};
    localparam logic [31:0] OP11   = {4'hE, 2'b11, 26'h0123456};

    initial begin
        reset = 1'b1;
        bus.Instr = 32'h0;
        bus.ALUFlags = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outs("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_flags", 32'(dut.flags_q), 32'd0);
        check("rst_cond", 32'(dut.cond_q), 32'd0);

        run_instr("adds", ADDS, 4'b0100, -1);
        run_instr("cmp_z", CMP_RR, 4'b0100, -1);
        run_instr("beq", BEQ, -1, -1);
        run_instr("bne", BNE, -1, -1);
        run_instr("ldr", LDR_D, -1, -1);
        run_instr("strne", STRNE, -1, -1);
        run_instr("mov", MOV_I, -1, -1);
        run_instr("op11", OP11, -1, -1);
        run_instr("str_rst", STR_AL, -1, 3);
        run_instr("after_rst", ADDS, 4'b1001, -1);

        for (int k = 0; k < 400; k++)
            run_instr($sformatf("r%0d", k), rand_instr(), -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the ARM datapath: a Moore main FSM plus instruction, ALU and condition decoding. It consumes `Instr` and `ALUFlags` from the datapath and drives every datapath select and enable. It also drives the data-memory write strobe. It holds the architectural NZCV flags register and a per-instruction condition bit.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `Instr` in 32: instruction register contents from the datapath.
- `ALUFlags` in 4: {N,Z,C,V} from the ALU, same cycle.
- `PCWrite`, `IRWrite`, `RegWrite`, `MemWrite` out 1: write enables.
- `AdrSrc`, `ALUSrcA`, `Shift` out 1: address, SrcA and move selects.
- `RegSrc` out 2:
  - bit0 selects R15 as RA1;
  - bit1 selects Rd as RA2.
- `ImmSrc` out 2: 00 imm8, 01 imm12, 10 branch imm24.
- `ALUSrcB` out 2: 00 shifted reg, 01 ExtImm, 10 constant 4.
- `ResultSrc` out 2: 00 ALUOut, 01 Data, 10 ShOut.
- `ALUControl` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
- **FETCH:**
  - AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10.
  - IRWrite=1, PCWrite=1.
  - Next state: DECODE.
- **DECODE:**
  - ALUSrcA=1, ALUSrcB=10, ResultSrc=10 (computes PC+8).
  - Captures `cond_q`.
  - Next state by `Op=Instr[27:26]`:
    - 01 → MEMADR.
    - 00 with I=`Instr[25]` → EXECI, else EXECR.
    - 10 → BRANCH.
    - 11, or an unsupported cmd → FETCH, with no writes.
- **MEMADR:**
  - ALUSrcA=0, ALUSrcB=01.
  - ALUControl=00 if U=`Instr[23]`=1, else 01.
  - Next state: MEMREAD if L=`Instr[20]`, else MEMWRITE.
- **MEMREAD:** AdrSrc=1, ResultSrc=00. Next state: MEMWB.
- **MEMWB:** ResultSrc=01, RegWrite=`cond_q`. Next state: FETCH.
- **MEMWRITE:** AdrSrc=1, MemWrite=`cond_q`. Next state: FETCH.
- **EXECR / EXECI:**
  - ALUSrcA=0, ALUSrcB=00 (EXECR) or 01 (EXECI).
  - ALUControl comes from cmd=`Instr[24:21]`:

    | cmd | operation | ALUControl |
    |---|---|---|
    | 0100 | ADD | 00 |
    | 0010 | SUB | 01 |
    | 0000 | AND | 10 |
    | 1100 | ORR | 11 |
    | 1010 | CMP | 01 |
    | 1101 | MOV | Shift=1 |

  - Next state: ALUWB.
- **ALUWB:** ResultSrc=00, RegWrite=`cond_q` & ~CMP.
- **BRANCH:**
  - RegSrc0=1, ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10.
  - PCWrite=`cond_q`.
- **Register-writing states:**
  - RegSrc1=1 in MEMADR and MEMWRITE.
  - ImmSrc follows Op in all states.
  - Rd=15 in MEMWB or ALUWB also asserts PCWrite=`cond_q`.
- **Flags:**
  - Update at the EXECR/EXECI clock edge when `cond_q`=1 and the instruction sets flags (S=`Instr[20]`, or CMP).
  - ADD, SUB and CMP write NZCV.
  - AND, ORR and MOV write NZ only.
- **Condition evaluation:**
  - Uses the standard ARM 14 conditions against the flags register.
  - 1110 is always true.
  - 1111 is never true.

## Timing
- Cycles per instruction:
  - B: 3.
  - STR, DP, CMP, MOV: 4.
  - LDR: 5.
  - Unknown: 2.
- All outputs decode combinationally from state and `Instr` (Moore plus instruction fields). They have no added latency.
- `cond_q` is sampled at the end of DECODE. A flag update during EXEC does not alter the same instruction's ALUWB gating.
- Reset values:
  - state=FETCH, NZCV=0000, `cond_q`=0.
  - While `reset`=1: PCWrite, IRWrite, RegWrite and MemWrite are forced to 0; selects take their FETCH values.
- Reset mid-instruction: no write occurs in the reset cycle. The first cycle after reset deasserts is FETCH.
- A failed condition still walks the full state sequence, with all writes suppressed.

## Configuration
- `MC_CTRL_SHIFT_EN` defined:
  - MOV (cmd 1101) asserts Shift=1 in EXECR/EXECI and writes back through ALUWB.
- `MC_CTRL_SHIFT_EN` undefined:
  - Shift is tied to 0.
  - cmd 1101 is unsupported, so DECODE goes to FETCH with no write.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - Op, cmd and ALUControl encoding constants;
  - the ResultSrc and ALUSrcB encodings.
- Sub-module `mc_condcheck`: combinational Cond[3:0] × NZCV → CondEx.
- The flags register and `cond_q` stay in the top level.

## Test plan
- **Reset mid-instruction:** reset during MEMWRITE → MemWrite=0 that cycle; FETCH with IRWrite=1 on the next cycle.
- **ADD with S:** ADDS R1,R2,R3 giving ALUFlags=0100 → 4-cycle sequence; RegWrite=1 in ALUWB; flags=0100 afterwards.
- **CMP then BEQ:** CMP with Z result, then BEQ → BRANCH asserts PCWrite=1. BNE in the same situation → PCWrite=0.
- **LDR:** LDR with U=0 → ALUControl=01 in MEMADR; RegWrite=1 only in MEMWB; 5 cycles total.
- **Failed condition:** STRNE with Z=1 → MemWrite=0 throughout; returns to FETCH after 4 cycles.
- **MOV and unknown Op:**
  - MOV R0,#5 → Shift=1 in EXECI, RegWrite=1 in ALUWB. Without the macro, DECODE goes to FETCH instead.
  - Op=11 → DECODE goes to FETCH.
